ucie_ctl_rx_flow_ctrl: RTL

//  Parametrised RX-side flow controller for the UCIe controller RX path. Tracks RX

---
 rtl/ucie_ctl_rx_flow_ctrl_if.sv | 29 ++
 rtl/ucie_ctl_rx_flow_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_rx_flow_ctrl_if.sv
// Handshake and status bundle between the RX flow controller and its requester.
// The RX buffer also uses this bundle.
interface ucie_ctl_rx_flow_ctrl_if #(
  parameter int REQ_W = 4,
  parameter int CNT_W = 5
);
  logic [REQ_W-1:0] i_state_request;
  logic             i_wr_valid;
  logic             i_rd_valid;
  logic             o_wr_accept;
  logic             o_buffer_enable;
  logic             o_overflow_detected;
  logic             o_almost_full;
  logic [CNT_W-1:0] o_occupancy;
  logic [7:0]       o_overflow_count;
  logic [1:0]       o_state;

  modport master (
    output i_state_request, i_wr_valid, i_rd_valid,
    input  o_wr_accept, o_buffer_enable, o_overflow_detected, o_almost_full,
    input  o_occupancy, o_overflow_count, o_state
  );

  modport slave (
    input  i_state_request, i_wr_valid, i_rd_valid,
    output o_wr_accept, o_buffer_enable, o_overflow_detected, o_almost_full,
    output o_occupancy, o_overflow_count, o_state
  );
endinterface

// File: rtl/ucie_ctl_rx_flow_ctrl.sv
// RX flow controller: tracks RX buffer occupancy and gates writes.
// It runs the IDLE/ACTIVE/DRAIN/OVERFLOW control with a timed overflow hold.
module ucie_ctl_rx_flow_ctrl #(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int OVF_HOLD  = 4,
  parameter int REQ_W     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  ucie_ctl_rx_flow_ctrl_if.slave   rx_if
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int HOLD_W = $clog2(OVF_HOLD + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_C      = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  OCC_ZERO  = {CNT_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OVF_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_OVERFLOW = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              buf_en_q, buf_en_d;
  logic              ovf_det_q, ovf_det_d;
  logic              af_q, af_d;

  logic [REQ_W-1:0]  req_s;
  logic              req_act_s;
  logic              wr_accept_s;
  logic              rd_eff_s;
  logic              ovf_evt_s;

  assign req_s     = rx_if.i_state_request;
  assign req_act_s = |req_s;

  // Write accept, effective read and overflow event decode from current state.
  always_comb begin
    wr_accept_s = (state_q == ST_ACTIVE) && rx_if.i_wr_valid &&
                  ((occ_q < DEPTH_C) || rx_if.i_rd_valid);
    rd_eff_s    = rx_if.i_rd_valid && (occ_q != OCC_ZERO);
    ovf_evt_s   = (state_q == ST_ACTIVE) && rx_if.i_wr_valid &&
                  (occ_q == DEPTH_C) && !rx_if.i_rd_valid;
  end

  // Next-state computation for occupancy, event count, hold timer and FSM.
  always_comb begin
    occ_d   = occ_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    hold_d  = hold_q;

    if (wr_accept_s && !rd_eff_s) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!wr_accept_s && rd_eff_s) begin
      occ_d = occ_q - CNT_W'(1);
    end else begin
      occ_d = occ_q;
    end

    if (ovf_evt_s && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_act_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // Overflow wins over a simultaneous request drop.
        if (ovf_evt_s) begin
          state_d = ST_OVERFLOW;
          hold_d  = HOLD_LOAD;
        end else if (!req_act_s) begin
          if (occ_d != OCC_ZERO) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DRAIN: begin
        if (req_act_s) begin
          state_d = ST_ACTIVE;
        end else if (occ_d == OCC_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_OVERFLOW: begin
        if (hold_q != HOLD_ZERO) begin
          hold_d  = hold_q - HOLD_W'(1);
          state_d = ST_OVERFLOW;
        end else if (req_act_s) begin
          state_d = ST_ACTIVE;
        end else if (occ_q != OCC_ZERO) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = HOLD_ZERO;
      end
    endcase

    buf_en_d  = (state_d == ST_ACTIVE);
    ovf_det_d = (state_d == ST_OVERFLOW);
    af_d      = (occ_d >= AF_C);
  end

  // State and registered-output flops; async reset clears everything at once.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      occ_q     <= OCC_ZERO;
      cnt_q     <= 8'd0;
      hold_q    <= HOLD_ZERO;
      buf_en_q  <= 1'b0;
      ovf_det_q <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      buf_en_q  <= buf_en_d;
      ovf_det_q <= ovf_det_d;
      af_q      <= af_d;
    end
  end

  assign rx_if.o_wr_accept         = wr_accept_s;
  assign rx_if.o_buffer_enable     = buf_en_q;
  assign rx_if.o_overflow_detected = ovf_det_q;
  assign rx_if.o_almost_full       = af_q;
  assign rx_if.o_occupancy         = occ_q;
  assign rx_if.o_overflow_count    = cnt_q;
  assign rx_if.o_state             = state_q;

endmodule
